// File: rtl/sevenseg_scan_if.sv
// Display-side bundle for sevenseg_scan: the digit/control inputs and the
// active-low segment, dot and anode drives.
interface sevenseg_scan_if;
  logic        en;
  logic [23:0] bcd_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  an;

  modport master (output en, bcd_in, blank_lz, input seg, dp, an);
  modport slave  (input en, bcd_in, blank_lz, output seg, dp, an);
endinterface

// File: rtl/sevenseg_scan.sv
// Six-digit common-anode seven-segment scanner with dead time, frame-coherent
// digit capture and separator dots. Define SEP_BLINK_EN to blink the separators.
module sevenseg_scan #(
  parameter int DIGIT_CLKS = 100_000,
  parameter int BLANK_CLKS = 1_000,
  parameter int BLINK_CLKS = 50_000_000
) (
  input  logic            clk,
  input  logic            rst,
  sevenseg_scan_if.slave  dsp
);

  localparam int CNT_W = (DIGIT_CLKS > 1) ? $clog2(DIGIT_CLKS) : 1;

  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       idx_r;
  logic [23:0]      shadow_r;
  logic [6:0]       seg_r;
  logic             dp_r;
  logic [5:0]       an_r;

  logic             slot_end_s;
  logic             in_blank_s;
  logic             sep_on_s;
  logic [3:0]       digit_s;
  logic [6:0]       seg_n_s;
  logic             dp_n_s;
  logic [5:0]       an_n_s;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;  // non-BCD shows a dash
    endcase
    return s;
  endfunction

  assign slot_end_s = (cnt_r == CNT_W'(DIGIT_CLKS - 1));
  assign in_blank_s = (cnt_r < CNT_W'(BLANK_CLKS));

  // Slot timer, digit index and end-of-frame shadow capture; all frozen while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= '0;
      idx_r    <= 3'd0;
      shadow_r <= 24'h000000;
    end else if (dsp.en) begin
      if (slot_end_s) begin
        cnt_r <= '0;
        if (idx_r == 3'd5) begin
          idx_r    <= 3'd0;
          shadow_r <= dsp.bcd_in;
        end else begin
          idx_r    <= idx_r + 3'd1;
        end
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

`ifdef SEP_BLINK_EN
  localparam int BLK_W = (BLINK_CLKS > 1) ? $clog2(BLINK_CLKS) : 1;

  logic [BLK_W-1:0] blink_cnt_r;
  logic             phase_r;

  // Separator blink timebase, advancing only while the display is enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_r <= '0;
      phase_r     <= 1'b0;
    end else if (dsp.en) begin
      if (blink_cnt_r == BLK_W'(BLINK_CLKS - 1)) begin
        blink_cnt_r <= '0;
        phase_r     <= ~phase_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BLK_W'(1);
      end
    end
  end

  assign sep_on_s = phase_r;
`else
  assign sep_on_s = 1'b1;
`endif

  // Select the shadow digit for the current slot.
  always_comb begin
    digit_s = 4'd0;
    case (idx_r)
      3'd0:    digit_s = shadow_r[3:0];
      3'd1:    digit_s = shadow_r[7:4];
      3'd2:    digit_s = shadow_r[11:8];
      3'd3:    digit_s = shadow_r[15:12];
      3'd4:    digit_s = shadow_r[19:16];
      3'd5:    digit_s = shadow_r[23:20];
      default: digit_s = 4'd0;
    endcase
  end

  // Next output drive: dark when disabled or in dead time, else the decoded slot.
  always_comb begin
    an_n_s  = 6'h3F;
    seg_n_s = 7'h7F;
    dp_n_s  = 1'b1;
    if (dsp.en && !in_blank_s) begin
      an_n_s = ~(6'b000001 << idx_r);
      if ((idx_r == 3'd5) && dsp.blank_lz && (digit_s == 4'd0)) begin
        seg_n_s = 7'h7F;
      end else begin
        seg_n_s = seg_decode(digit_s);
      end
      if (((idx_r == 3'd2) || (idx_r == 3'd4)) && sep_on_s) begin
        dp_n_s = 1'b0;
      end else begin
        dp_n_s = 1'b1;
      end
    end else begin
      an_n_s  = 6'h3F;
      seg_n_s = 7'h7F;
      dp_n_s  = 1'b1;
    end
  end

  // Registered pin drive; reset blanks the display asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_r  <= 6'h3F;
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_n_s;
      seg_r <= seg_n_s;
      dp_r  <= dp_n_s;
    end
  end

  assign dsp.an  = an_r;
  assign dsp.seg = seg_r;
  assign dsp.dp  = dp_r;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan: stimulus pushes the expected pin drive
// for each clock, a monitor pops and compares it after every rising edge.
module tb_sevenseg_scan;
  localparam int DC = 8;
  localparam int BC = 2;
  localparam int LC = 16;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sevenseg_scan_if dif ();

  sevenseg_scan #(.DIGIT_CLKS(DC), .BLANK_CLKS(BC), .BLINK_CLKS(LC)) dut (
    .clk (clk),
    .rst (rst),
    .dsp (dif)
  );

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  int          m_cnt;
  int          m_idx;
  logic [23:0] m_shadow;
  int          m_bcnt;
  logic        m_phase;

  function automatic logic [6:0] exp_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt    = 0;
    m_idx    = 0;
    m_shadow = 24'h000000;
    m_bcnt   = 0;
    m_phase  = 1'b0;
  endtask

  task automatic chk(input string name, input logic [13:0] got, input logic [13:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Drive one clock of inputs (called at a falling edge) and queue the expected drive.
  task automatic step(input logic e, input logic [23:0] b, input logic lz);
    exp_t       x;
    logic [3:0] d;
    logic       sep_lit;
    dif.en       = e;
    dif.bcd_in   = b;
    dif.blank_lz = lz;
`ifdef SEP_BLINK_EN
    sep_lit = m_phase;
`else
    sep_lit = 1'b1;
`endif
    x.an  = 6'h3F;
    x.seg = 7'h7F;
    x.dp  = 1'b1;
    if (e && (m_cnt >= BC)) begin
      d = m_shadow[m_idx*4 +: 4];
      x.an[m_idx] = 1'b0;
      x.seg = (m_idx == 5 && lz && d == 4'd0) ? 7'h7F : exp_seg(d);
      x.dp  = ((m_idx == 2 || m_idx == 4) && sep_lit) ? 1'b0 : 1'b1;
    end
    exp_q.push_back(x);
    if (e) begin
      if (m_cnt == DC - 1) begin
        m_cnt = 0;
        if (m_idx == 5) begin
          m_idx    = 0;
          m_shadow = b;
        end else begin
          m_idx = m_idx + 1;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
      if (m_bcnt == LC - 1) begin
        m_bcnt  = 0;
        m_phase = ~m_phase;
      end else begin
        m_bcnt = m_bcnt + 1;
      end
    end
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checks++;
        if ({dif.an, dif.seg, dif.dp} !== x) begin
          failures++;
          $display("FAIL scan_out t=%0t got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                   $time, dif.an, dif.seg, dif.dp, x.an, x.seg, x.dp);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst          = 1'b1;
    dif.en       = 1'b0;
    dif.bcd_in   = 24'h000000;
    dif.blank_lz = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_out", {dif.an, dif.seg, dif.dp}, {6'h3F, 7'h7F, 1'b1});
    rst = 1'b0;

    // Frame 1 shows zeros, frame 2 shows 12:34:56.
    repeat (96) step(1'b1, 24'h123456, 1'b0);

    // Capture 23:59:59, then switch input to zeros mid-frame at idx 3.
    repeat (48) step(1'b1, 24'h235959, 1'b0);
    while (m_idx != 3) step(1'b1, 24'h235959, 1'b0);
    while (!(m_idx == 0 && m_cnt == 0)) step(1'b1, 24'h000000, 1'b0);
    repeat (48) step(1'b1, 24'h000000, 1'b0);

    // Illegal digit and leading-zero blanking.
    repeat (96) step(1'b1, 24'h0A1234, 1'b1);

    // Pause at idx 3, cnt 5 for 20 cycles, then resume.
    while (!(m_idx == 3 && m_cnt == 5)) step(1'b1, 24'h0A1234, 1'b1);
    repeat (20) step(1'b0, 24'h0A1234, 1'b1);
    repeat (48) step(1'b1, 24'h0A1234, 1'b1);

    // Asynchronous reset in the middle of the h1 slot (showing a dash).
    while (!(m_idx == 4 && m_cnt == 6)) step(1'b1, 24'h123456, 1'b0);
    chk("pre_rst_an_seg", {1'b0, dif.an, dif.seg}, {1'b0, 6'h2F, 7'h3F});
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {dif.an, dif.seg, dif.dp}, {6'h3F, 7'h7F, 1'b1});
    @(negedge clk);
    @(negedge clk);
    chk("held_rst", {dif.an, dif.seg, dif.dp}, {6'h3F, 7'h7F, 1'b1});
    rst = 1'b0;
    model_reset();
    repeat (96) step(1'b1, 24'h123456, 1'b0);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drained got=%0d want=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
